// File: rtl/segre_pkg.sv
// Shared memory-op and store-buffer types for the segre core.
package segre_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } sb_state_e;

    function automatic logic [7:0] type_mask(input memop_data_type_e t);
        unique case (t)
            BYTE:    type_mask = 8'h01;
            HALF:    type_mask = 8'h03;
            default: type_mask = 8'h0f;
        endcase
    endfunction

    // Address bits below the access size are ignored.
    function automatic logic [2:0] align_off(input memop_data_type_e t,
                                             input logic [2:0] off);
        unique case (t)
            BYTE:    align_off = off;
            HALF:    align_off = {off[2:1], 1'b0};
            default: align_off = {off[2], 2'b00};
        endcase
    endfunction

endpackage

// File: rtl/segre_sb_fwd_unit.sv
// Per-lane store-to-load forwarding; youngest matching entry wins.
module segre_sb_fwd_unit
    import segre_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                      ld_valid_i,
    input  logic [ADDR_WIDTH-1:0]                     ld_addr_i,
    input  memop_data_type_e                          ld_type_i,
    input  logic [NUM_ENTRIES-1:0]                    ent_valid_i,
    input  logic [NUM_ENTRIES-1:0][ADDR_WIDTH-1:0]    ent_addr_i,
    input  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0]    ent_data_i,
    input  logic [NUM_ENTRIES-1:0][DATA_WIDTH/8-1:0]  ent_be_i,
    input  logic [$clog2(NUM_ENTRIES)-1:0]            rd_ptr_i,
    output logic                                      ld_hit_o,
    output logic                                      ld_conflict_o,
    output logic [DATA_WIDTH-1:0]                     ld_data_o
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(NUM_ENTRIES);

    logic [2:0]            off;
    logic [NB-1:0]         req_be;
    logic [NB-1:0]         fwd_be;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PW-1:0]         idx;

    // Scan oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        off      = align_off(ld_type_i, 3'(ld_addr_i[OFFW-1:0]));
        req_be   = NB'(type_mask(ld_type_i) << off);
        fwd_be   = '0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            idx = rd_ptr_i + PW'(i);
            if (ent_valid_i[idx] &&
                ent_addr_i[idx][ADDR_WIDTH-1:OFFW] == ld_addr_i[ADDR_WIDTH-1:OFFW]) begin
                for (int l = 0; l < NB; l++) begin
                    if (ent_be_i[idx][l] && req_be[l]) begin
                        fwd_be[l]         = 1'b1;
                        fwd_data[l*8 +: 8] = ent_data_i[idx][l*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        ld_hit_o      = ld_valid_i && (fwd_be == req_be);
        ld_conflict_o = ld_valid_i && (fwd_be != '0) && (fwd_be != req_be);
        ld_data_o     = ld_valid_i ? (fwd_data >> {off, 3'b000}) : '0;
    end

endmodule

// File: rtl/segre_param_store_buffer.sv
// Circular store buffer with load forwarding and IDLE/FLUSH drain control.
// Define SEGRE_SB_COALESCE_EN to merge same-word stores into the youngest entry.
module segre_param_store_buffer
    import segre_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          st_valid_i,
    output logic                          st_ready_o,
    input  logic [ADDR_WIDTH-1:0]         st_addr_i,
    input  logic [DATA_WIDTH-1:0]         st_data_i,
    input  memop_data_type_e              st_type_i,
    input  logic                          ld_valid_i,
    input  logic [ADDR_WIDTH-1:0]         ld_addr_i,
    input  memop_data_type_e              ld_type_i,
    output logic                          ld_hit_o,
    output logic [DATA_WIDTH-1:0]         ld_data_o,
    output logic                          ld_conflict_o,
    input  logic                          flush_req_i,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_data_o,
    output logic [DATA_WIDTH/8-1:0]       mem_be_o,
    output logic [$clog2(NUM_ENTRIES):0]  count_o,
    output logic                          empty_o,
    output logic                          full_o
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(NUM_ENTRIES);
    localparam int CW   = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [NB-1:0]         be;
        logic                  valid;
    } sb_entry_t;

    sb_entry_t             entries [NUM_ENTRIES];
    sb_state_e             state_q, state_d;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  deq, alloc, merge;
    logic [2:0]            st_off;
    logic [NB-1:0]         st_be;
    logic [DATA_WIDTH-1:0] st_shift, st_wdata;
    logic [ADDR_WIDTH-1:0] st_waddr;

    logic [NUM_ENTRIES-1:0]                 ent_valid;
    logic [NUM_ENTRIES-1:0][ADDR_WIDTH-1:0] ent_addr;
    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] ent_data;
    logic [NUM_ENTRIES-1:0][NB-1:0]         ent_be;

    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(NUM_ENTRIES));
    assign mem_valid_o = !empty_o;
    assign deq         = mem_valid_o && mem_ready_i;
    assign mem_addr_o  = mem_valid_o ? entries[rd_ptr_q].addr : '0;
    assign mem_data_o  = mem_valid_o ? entries[rd_ptr_q].data : '0;
    assign mem_be_o    = mem_valid_o ? entries[rd_ptr_q].be   : '0;

    always_comb begin
        st_off   = align_off(st_type_i, 3'(st_addr_i[OFFW-1:0]));
        st_be    = NB'(type_mask(st_type_i) << st_off);
        st_shift = st_data_i << {st_off, 3'b000};
        st_waddr = {st_addr_i[ADDR_WIDTH-1:OFFW], OFFW'(0)};
        st_wdata = '0;
        for (int l = 0; l < NB; l++)
            if (st_be[l]) st_wdata[l*8 +: 8] = st_shift[l*8 +: 8];
    end

`ifdef SEGRE_SB_COALESCE_EN
    logic [PW-1:0]         last_ptr;
    logic [DATA_WIDTH-1:0] merge_data;

    assign last_ptr = wr_ptr_q - PW'(1);
    // The head may be absorbing a merge only if it is not leaving this cycle.
    assign merge = !empty_o && entries[last_ptr].valid
                && (entries[last_ptr].addr == st_waddr)
                && !(deq && count_q == CW'(1));

    always_comb begin
        merge_data = entries[last_ptr].data;
        for (int l = 0; l < NB; l++)
            if (st_be[l]) merge_data[l*8 +: 8] = st_wdata[l*8 +: 8];
    end

    assign st_ready_o = (state_q == IDLE) && (!full_o || merge);
`else
    assign merge      = 1'b0;
    assign st_ready_o = (state_q == IDLE) && !full_o;
`endif

    assign alloc   = st_valid_i && st_ready_o && !merge;
    assign count_d = count_q + CW'(alloc) - CW'(deq);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if ((flush_req_i && !empty_o) || ld_conflict_o) state_d = FLUSH;
            FLUSH:   if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (deq) begin
                entries[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (alloc) begin
                entries[wr_ptr_q] <= '{addr: st_waddr, data: st_wdata,
                                       be: st_be, valid: 1'b1};
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
`ifdef SEGRE_SB_COALESCE_EN
            if (st_valid_i && st_ready_o && merge) begin
                entries[last_ptr].data <= merge_data;
                entries[last_ptr].be   <= entries[last_ptr].be | st_be;
            end
`endif
        end
    end

    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        ent_data  = '0;
        ent_be    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_addr[i]  = entries[i].addr;
            ent_data[i]  = entries[i].data;
            ent_be[i]    = entries[i].be;
        end
    end

    segre_sb_fwd_unit #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_fwd (
        .ld_valid_i    (ld_valid_i),
        .ld_addr_i     (ld_addr_i),
        .ld_type_i     (ld_type_i),
        .ent_valid_i   (ent_valid),
        .ent_addr_i    (ent_addr),
        .ent_data_i    (ent_data),
        .ent_be_i      (ent_be),
        .rd_ptr_i      (rd_ptr_q),
        .ld_hit_o      (ld_hit_o),
        .ld_conflict_o (ld_conflict_o),
        .ld_data_o     (ld_data_o)
    );

endmodule

// File: tb/tb_segre_param_store_buffer.sv
// Self-checking bench for segre_param_store_buffer (default 8 x 32-bit).
module tb_segre_param_store_buffer;
    import segre_pkg::*;

`ifdef SEGRE_SB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif
    localparam int N = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    logic st_valid_i, st_ready_o;
    logic [31:0] st_addr_i, st_data_i;
    memop_data_type_e st_type_i, ld_type_i;
    logic ld_valid_i, ld_hit_o, ld_conflict_o;
    logic [31:0] ld_addr_i, ld_data_o;
    logic flush_req_i, mem_valid_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0] mem_be_o;
    logic [3:0] count_o;
    logic empty_o, full_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    segre_param_store_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
        .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_type_i(st_type_i),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_type_i(ld_type_i),
        .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_conflict_o(ld_conflict_o),
        .flush_req_i(flush_req_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input memop_data_type_e stt, input logic lv, input logic [31:0] la,
                         input memop_data_type_e lt, input logic mr, input logic fl);
        st_valid_i = sv; st_addr_i = sa; st_data_i = sd; st_type_i = stt;
        ld_valid_i = lv; ld_addr_i = la; ld_type_i = lt;
        mem_ready_i = mr; flush_req_i = fl;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Reference model: a queue of byte-granular entries, oldest at index 0.
    typedef struct {
        int unsigned waddr;
        logic [7:0]  b [4];
        logic [3:0]  be;
    } ment_t;
    ment_t mq[$];
    bit    mflush;

    function automatic int szof(input memop_data_type_e t);
        return (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
    endfunction

    function automatic int alof(input logic [31:0] a, input memop_data_type_e t);
        int o;
        o = int'(a[1:0]);
        return o - (o % szof(t));
    endfunction

    function automatic bit m_merge(input logic [31:0] a, input bit deq);
        if (!COAL || mq.size() == 0) return 1'b0;
        if (deq && mq.size() == 1) return 1'b0;
        return mq[mq.size()-1].waddr == (a & 32'hFFFF_FFFC);
    endfunction

    function automatic void m_fwd(input logic v, input logic [31:0] a, input memop_data_type_e t,
                                  output logic hit, output logic conf, output logic [31:0] d);
        int sz, off, found;
        sz = szof(t); off = alof(a, t); found = 0; d = '0;
        if (v) begin
            for (int l = off; l < off + sz; l++) begin
                for (int k = mq.size() - 1; k >= 0; k--) begin
                    if (mq[k].waddr == (a & 32'hFFFF_FFFC) && mq[k].be[l]) begin
                        d = d | (32'(mq[k].b[l]) << (8 * (l - off)));
                        found++;
                        break;
                    end
                end
            end
        end
        hit  = v && (found == sz);
        conf = v && (found > 0) && (found < sz);
    endfunction

    function automatic void m_edge(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                   input memop_data_type_e stt, input logic rdy, input bit mrg,
                                   input logic mr, input logic fl, input logic conf);
        int sz, off, pre;
        ment_t e;
        pre = mq.size();
        if (pre > 0 && mr) void'(mq.pop_front());
        if (sv && rdy) begin
            sz = szof(stt); off = alof(sa, stt);
            if (mrg) e = mq[mq.size()-1];
            else begin
                e.waddr = sa & 32'hFFFF_FFFC; e.be = '0;
                for (int l = 0; l < 4; l++) e.b[l] = 8'h00;
            end
            for (int l = off; l < off + sz; l++) begin
                e.b[l] = 8'(sd >> (8 * (l - off)));
                e.be[l] = 1'b1;
            end
            if (mrg) mq[mq.size()-1] = e;
            else mq.push_back(e);
        end
        if (!mflush) begin
            if ((fl && pre > 0) || conf) mflush = 1'b1;
        end else if (mq.size() == 0) mflush = 1'b0;
    endfunction

    typedef struct {
        logic st_v; logic [31:0] st_a; logic [31:0] st_d; memop_data_type_e st_t;
        logic ld_v; logic [31:0] ld_a; memop_data_type_e ld_t;
        logic mr; logic fl;
        logic e_rdy; logic e_hit; logic e_conf; logic [31:0] e_data; int e_cnt;
    } vec_t;
    vec_t tbl [19];

    initial begin
        logic eh, ec, er;
        logic [31:0] ed, emd;
        bit mrg;

        tbl[0]  = '{1, 32'h100, 32'hDEADBEEF, WORD, 0, 32'h0,   BYTE, 0, 0, 1, 0, 0, 32'h0,        0};
        tbl[1]  = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h100, WORD, 0, 0, 1, 1, 0, 32'hDEADBEEF, 1};
        tbl[2]  = '{1, 32'h105, 32'hFFFF_FFAA, BYTE, 1, 32'h105, BYTE, 0, 0, 1, 0, 0, 32'h0,       1};
        tbl[3]  = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h105, BYTE, 0, 0, 1, 1, 0, 32'hAA,       2};
        tbl[4]  = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h102, HALF, 0, 0, 1, 1, 0, 32'hDEAD,     2};
        tbl[5]  = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h103, HALF, 0, 0, 1, 1, 0, 32'hDEAD,     2};
        tbl[6]  = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h108, WORD, 0, 0, 1, 0, 0, 32'h0,        2};
        tbl[7]  = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h104, WORD, 0, 0, 1, 0, 1, 32'h0000AA00, 2};
        tbl[8]  = '{1, 32'h400, 32'h1234,     WORD, 0, 32'h0,   BYTE, 0, 0, 0, 0, 0, 32'h0,        2};
        tbl[9]  = '{1, 32'h400, 32'h1234,     WORD, 1, 32'h105, BYTE, 1, 0, 0, 1, 0, 32'hAA,       2};
        tbl[10] = '{1, 32'h400, 32'h1234,     WORD, 0, 32'h0,   BYTE, 1, 0, 0, 0, 0, 32'h0,        1};
        tbl[11] = '{1, 32'h400, 32'h1234,     WORD, 0, 32'h0,   BYTE, 0, 0, 1, 0, 0, 32'h0,        0};
        tbl[12] = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h400, WORD, 0, 0, 1, 1, 0, 32'h1234,     1};
        tbl[13] = '{0, 32'h0,   32'h0,        BYTE, 0, 32'h0,   BYTE, 0, 1, 1, 0, 0, 32'h0,        1};
        tbl[14] = '{1, 32'h500, 32'h5,        WORD, 0, 32'h0,   BYTE, 0, 0, 0, 0, 0, 32'h0,        1};
        tbl[15] = '{0, 32'h0,   32'h0,        BYTE, 0, 32'h0,   BYTE, 1, 0, 0, 0, 0, 32'h0,        1};
        tbl[16] = '{0, 32'h0,   32'h0,        BYTE, 0, 32'h0,   BYTE, 0, 1, 1, 0, 0, 32'h0,        0};
        tbl[17] = '{1, 32'h504, 32'h77,       WORD, 0, 32'h0,   BYTE, 0, 0, 1, 0, 0, 32'h0,        0};
        tbl[18] = '{0, 32'h0,   32'h0,        BYTE, 1, 32'h504, WORD, 0, 0, 1, 1, 0, 32'h77,       1};

        drive(0, 0, 0, BYTE, 1, 32'h100, WORD, 0, 0);
        do_reset();
        #2;
        chk("rst.empty", empty_o, 1);
        chk("rst.full", full_o, 0);
        chk("rst.count", count_o, 0);
        chk("rst.mem_valid", mem_valid_o, 0);
        chk("rst.mem_addr", mem_addr_o, 0);
        chk("rst.mem_be", mem_be_o, 0);
        chk("rst.st_ready", st_ready_o, 1);
        chk("rst.hit", ld_hit_o, 0);
        chk("rst.conflict", ld_conflict_o, 0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk_i);
            drive(tbl[i].st_v, tbl[i].st_a, tbl[i].st_d, tbl[i].st_t,
                  tbl[i].ld_v, tbl[i].ld_a, tbl[i].ld_t, tbl[i].mr, tbl[i].fl);
            #2;
            chk($sformatf("v%0d.st_ready", i), st_ready_o, tbl[i].e_rdy);
            chk($sformatf("v%0d.hit", i), ld_hit_o, tbl[i].e_hit);
            chk($sformatf("v%0d.conflict", i), ld_conflict_o, tbl[i].e_conf);
            chk($sformatf("v%0d.ld_data", i), ld_data_o, tbl[i].e_data);
            chk($sformatf("v%0d.count", i), count_o, 64'(tbl[i].e_cnt));
        end

        // Drain the leftover entry, then fill to full starting mid-ring.
        @(negedge clk_i); drive(0, 0, 0, BYTE, 0, 0, BYTE, 1, 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            drive(1, 32'h1000 + 32'(4 * i), 32'(i + 1), WORD, 0, 0, BYTE, 0, 0);
            #2 chk($sformatf("fill%0d.st_ready", i), st_ready_o, 1);
        end
        @(negedge clk_i); drive(0, 0, 0, BYTE, 0, 0, BYTE, 0, 0);
        #2;
        chk("full.full", full_o, 1);
        chk("full.count", count_o, 8);
        chk("full.st_ready", st_ready_o, 0);
        @(negedge clk_i); drive(1, 32'h2000, 32'h99, WORD, 0, 0, BYTE, 1, 0);
        #2;
        chk("full_deq.st_ready", st_ready_o, 0);
        chk("drain0.addr", mem_addr_o, 32'h1000);
        for (int i = 1; i < N; i++) begin
            @(negedge clk_i); drive(0, 0, 0, BYTE, 0, 0, BYTE, 1, 0);
            #2;
            chk($sformatf("drain%0d.addr", i), mem_addr_o, 32'h1000 + 32'(4 * i));
            chk($sformatf("drain%0d.data", i), mem_data_o, 32'(i + 1));
        end
        @(negedge clk_i); drive(0, 0, 0, BYTE, 1, 32'h1004, WORD, 0, 0);
        #2;
        chk("drained.count", count_o, 0);
        chk("drained.empty", empty_o, 1);
        chk("drained.mem_valid", mem_valid_o, 0);
        chk("drained.hit", ld_hit_o, 0);

        // Word then byte into the same word.
        @(negedge clk_i); drive(1, 32'h200, 32'h11111111, WORD, 0, 0, BYTE, 0, 0);
        @(negedge clk_i); drive(1, 32'h200, 32'h22, BYTE, 0, 0, BYTE, 0, 0);
        @(negedge clk_i); drive(0, 0, 0, BYTE, 1, 32'h200, BYTE, 0, 0);
        #2;
        chk("ww.hit", ld_hit_o, 1);
        chk("ww.ld_data", ld_data_o, 32'h22);
        chk("ww.count", count_o, COAL ? 1 : 2);
        chk("ww.mem_be", mem_be_o, 4'hF);
        chk("ww.mem_data", mem_data_o, COAL ? 32'h11111122 : 32'h11111111);
        @(negedge clk_i); drive(0, 0, 0, BYTE, 1, 32'h200, WORD, 0, 0);
        #2 chk("ww.word", ld_data_o, 32'h11111122);

        // Async reset with entries held back by the cache.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); drive(1, 32'h300 + 32'(4 * i), 32'(i), WORD, 0, 0, BYTE, 0, 0);
        end
        @(negedge clk_i); drive(0, 0, 0, BYTE, 1, 32'h300, WORD, 0, 0);
        #1 chk("pre_rst.count", count_o, 3);
        #1 rst_i = 1'b1;
        #1;
        chk("arst.empty", empty_o, 1);
        chk("arst.mem_valid", mem_valid_o, 0);
        chk("arst.count", count_o, 0);
        chk("arst.hit", ld_hit_o, 0);
        @(negedge clk_i); rst_i = 1'b0;
        #2;
        chk("arst.st_ready", st_ready_o, 1);
        chk("arst.empty2", empty_o, 1);

        // Randomized traffic against the queue model.
        do_reset();
        mq.delete();
        mflush = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_i);
            drive(1'($urandom % 2), 32'h40 + ($urandom % 16), $urandom,
                  memop_data_type_e'($urandom % 3), 1'($urandom % 2), 32'h40 + ($urandom % 16),
                  memop_data_type_e'($urandom % 3), 1'($urandom % 2), ($urandom % 16) == 0);
            #2;
            mrg = m_merge(st_addr_i, (mq.size() > 0) && mem_ready_i);
            er = !mflush && (mq.size() < N || mrg);
            m_fwd(ld_valid_i, ld_addr_i, ld_type_i, eh, ec, ed);
            chk("rnd.st_ready", st_ready_o, er);
            chk("rnd.hit", ld_hit_o, eh);
            chk("rnd.conflict", ld_conflict_o, ec);
            chk("rnd.ld_data", ld_data_o, ed);
            chk("rnd.count", count_o, 64'(mq.size()));
            chk("rnd.mem_valid", mem_valid_o, mq.size() > 0);
            if (mq.size() > 0) begin
                emd = '0;
                for (int l = 0; l < 4; l++) emd = emd | (32'(mq[0].b[l]) << (8 * l));
                chk("rnd.mem_addr", mem_addr_o, mq[0].waddr);
                chk("rnd.mem_be", mem_be_o, mq[0].be);
                chk("rnd.mem_data", mem_data_o, emd);
            end
            m_edge(st_valid_i, st_addr_i, st_data_i, st_type_i, er, mrg,
                   mem_ready_i, flush_req_i, ec);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
